// File: rtl/decode_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decode_stage : RV32I instruction decoder behind one registered valid/ready stage
// Revision     : 1.0
// ----------------------------------------------------------------------------
module decode_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic [XLEN-1:0]  pc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  pc_out,
   output logic [4:0]       rd,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [XLEN-1:0]  imm,
   output logic [3:0]       alu_op,
   output logic [1:0]       a_sel,
   output logic             alu_src,
   output logic             rf_we,
   output logic             mem_we,
   output logic             mem_re,
   output logic [2:0]       mem_size,
   output logic             branch,
   output logic [2:0]       br_funct3,
   output logic             jump,
   output logic             jump_reg,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   localparam logic [6:0] c_op_imm = 7'b0010011;
   localparam logic [6:0] c_op     = 7'b0110011;
   localparam logic [6:0] c_load   = 7'b0000011;
   localparam logic [6:0] c_store  = 7'b0100011;
   localparam logic [6:0] c_branch = 7'b1100011;
   localparam logic [6:0] c_jal    = 7'b1101111;
   localparam logic [6:0] c_jalr   = 7'b1100111;
   localparam logic [6:0] c_lui    = 7'b0110111;
   localparam logic [6:0] c_auipc  = 7'b0010111;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] imm;
      logic [3:0]      alu_op;
      logic [1:0]      a_sel;
      logic            alu_src;
      logic            rf_we;
      logic            mem_we;
      logic            mem_re;
      logic [2:0]      funct3;
      logic            branch;
      logic            jump;
      logic            jump_reg;
      logic            illegal;
   } bundle_t;

   bundle_t          dec;
   bundle_t          bundle_d, bundle_q;
   logic             out_valid_d, out_valid_q;
   logic [CNT_W-1:0] illegal_cnt_d, illegal_cnt_q;

   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
   logic            capture;

   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   generate
      if (XLEN > 32) begin : g_imm_u_wide
         assign imm_u = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      end else begin : g_imm_u_narrow
         assign imm_u = {instr[31:12], 12'b0};
      end
   endgenerate

   always_comb begin
      dec          = '0;
      dec.pc       = pc;
      dec.rd       = instr[11:7];
      dec.rs1      = instr[19:15];
      dec.rs2      = instr[24:20];
      dec.funct3   = funct3;
      unique case (instr[6:0])
         c_op_imm: begin
            dec.imm     = imm_i;
            dec.alu_src = 1'b1;
            dec.rf_we   = 1'b1;
            dec.alu_op  = {(funct3 == 3'b101) ? instr[30] : 1'b0, funct3};
            if ((funct3 == 3'b001 && funct7 != 7'h00) ||
                (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20)) begin
               dec.illegal = 1'b1;
            end
         end
         c_op: begin
            if (funct7 == 7'h00) begin
               dec.alu_op = {1'b0, funct3};
               dec.rf_we  = 1'b1;
            end else if (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
               dec.alu_op = {1'b1, funct3};
               dec.rf_we  = 1'b1;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         c_load: begin
            dec.imm     = imm_i;
            dec.alu_src = 1'b1;
            unique case (funct3)
               3'b000, 3'b001, 3'b010, 3'b100, 3'b101: begin
                  dec.rf_we  = 1'b1;
                  dec.mem_re = 1'b1;
               end
               default: dec.illegal = 1'b1;
            endcase
         end
         c_store: begin
            dec.imm     = imm_s;
            dec.alu_src = 1'b1;
            if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010) begin
               dec.mem_we = 1'b1;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         c_branch: begin
            dec.imm = imm_b;
            if (funct3 == 3'b010 || funct3 == 3'b011) begin
               dec.illegal = 1'b1;
            end else begin
               dec.branch = 1'b1;
            end
         end
         c_jal: begin
            dec.imm   = imm_j;
            dec.jump  = 1'b1;
            dec.rf_we = 1'b1;
            dec.a_sel = 2'b01;
         end
         c_jalr: begin
            dec.imm     = imm_i;
            dec.alu_src = 1'b1;
            if (funct3 == 3'b000) begin
               dec.jump_reg = 1'b1;
               dec.rf_we    = 1'b1;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         c_lui: begin
            dec.imm     = imm_u;
            dec.a_sel   = 2'b10;
            dec.alu_src = 1'b1;
            dec.rf_we   = 1'b1;
         end
         c_auipc: begin
            dec.imm     = imm_u;
            dec.a_sel   = 2'b01;
            dec.alu_src = 1'b1;
            dec.rf_we   = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
      // An illegal encoding must never leave a side-effecting strobe set.
      if (dec.illegal) begin
         dec.rf_we    = 1'b0;
         dec.mem_we   = 1'b0;
         dec.mem_re   = 1'b0;
         dec.branch   = 1'b0;
         dec.jump     = 1'b0;
         dec.jump_reg = 1'b0;
      end
   end

   assign in_ready = !out_valid_q || out_ready;
   assign capture  = in_valid && in_ready && !flush;

   always_comb begin
      out_valid_d   = out_valid_q;
      bundle_d      = bundle_q;
      illegal_cnt_d = illegal_cnt_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (capture) begin
         out_valid_d = 1'b1;
         bundle_d    = dec;
         if (dec.illegal && illegal_cnt_q != {CNT_W{1'b1}}) begin
            illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q   <= 1'b0;
         bundle_q      <= '0;
         illegal_cnt_q <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         bundle_q      <= bundle_d;
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign pc_out      = bundle_q.pc;
   assign rd          = bundle_q.rd;
   assign rs1         = bundle_q.rs1;
   assign rs2         = bundle_q.rs2;
   assign imm         = bundle_q.imm;
   assign alu_op      = bundle_q.alu_op;
   assign a_sel       = bundle_q.a_sel;
   assign alu_src     = bundle_q.alu_src;
   assign mem_size    = bundle_q.funct3;
   assign br_funct3   = bundle_q.funct3;
   // Register contents linger after consume, so strobes are qualified here.
   assign rf_we       = out_valid_q && bundle_q.rf_we;
   assign mem_we      = out_valid_q && bundle_q.mem_we;
   assign mem_re      = out_valid_q && bundle_q.mem_re;
   assign branch      = out_valid_q && bundle_q.branch;
   assign jump        = out_valid_q && bundle_q.jump;
   assign jump_reg    = out_valid_q && bundle_q.jump_reg;
   assign illegal     = out_valid_q && bundle_q.illegal;
   assign illegal_cnt = illegal_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_decode_stage : directed + randomized checks of decode_stage against a reference model
// Revision        : 1.0
// ----------------------------------------------------------------------------
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic [31:0] instr = '0, pc = '0;

   logic        in_ready, out_valid, alu_src, rf_we, mem_we, mem_re, branch, jump, jump_reg, illegal;
   logic [31:0] pc_out, imm;
   logic [4:0]  rd, rs1, rs2;
   logic [3:0]  alu_op;
   logic [1:0]  a_sel;
   logic [2:0]  mem_size, br_funct3;
   logic [7:0]  illegal_cnt;

   logic        s_in_ready, s_out_valid, s_alu_src, s_rf_we, s_mem_we, s_mem_re;
   logic        s_branch, s_jump, s_jump_reg, s_illegal;
   logic [31:0] s_pc_out, s_imm;
   logic [4:0]  s_rd, s_rs1, s_rs2;
   logic [3:0]  s_alu_op;
   logic [1:0]  s_a_sel;
   logic [2:0]  s_mem_size, s_br_funct3;
   logic [1:0]  s_illegal_cnt;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out), .rd(rd),
      .rs1(rs1), .rs2(rs2), .imm(imm), .alu_op(alu_op), .a_sel(a_sel), .alu_src(alu_src),
      .rf_we(rf_we), .mem_we(mem_we), .mem_re(mem_re), .mem_size(mem_size), .branch(branch),
      .br_funct3(br_funct3), .jump(jump), .jump_reg(jump_reg), .illegal(illegal),
      .illegal_cnt(illegal_cnt)
   );

   decode_stage #(.XLEN(32), .CNT_W(2)) u_dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .instr(instr), .pc(pc),
      .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready), .pc_out(s_pc_out), .rd(s_rd),
      .rs1(s_rs1), .rs2(s_rs2), .imm(s_imm), .alu_op(s_alu_op), .a_sel(s_a_sel),
      .alu_src(s_alu_src), .rf_we(s_rf_we), .mem_we(s_mem_we), .mem_re(s_mem_re),
      .mem_size(s_mem_size), .branch(s_branch), .br_funct3(s_br_funct3), .jump(s_jump),
      .jump_reg(s_jump_reg), .illegal(s_illegal), .illegal_cnt(s_illegal_cnt)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic [31:0] imm;
      logic        imm_chk;
      logic [3:0]  alu_op;
      logic [1:0]  a_sel;
      logic        alu_src, rf_we, mem_we, mem_re, branch, jump, jump_reg, illegal;
   } dec_t;

   // Reference decoder: immediates are rebuilt numerically from bit weights.
   function automatic dec_t ref_decode(input logic [31:0] i);
      dec_t d;
      int   f3 = int'(i[14:12]);
      int   f7 = int'(i[31:25]);
      int   v_i = $signed(i) >>> 20;
      int   v_s = (($signed(i) >>> 25) * 32) + int'(i[11:7]);
      int   v_b = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      int   v_j = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
                  + int'(i[30:21]) * 2;
      int   v_u = int'(i & 32'hFFFF_F000);
      logic legal = 1'b1;
      d = '{default: '0};
      d.imm_chk = 1'b1;
      case (i[6:0])
         7'h13: begin
            legal = !((f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32));
            d.alu_op = 4'(f3 + ((f3 == 5 && i[30]) ? 8 : 0));
            d.alu_src = 1'b1; d.imm = 32'(v_i); d.rf_we = legal;
         end
         7'h33: begin
            legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
            d.alu_op = 4'(f3 + (f7 == 32 ? 8 : 0)); d.rf_we = legal; d.imm_chk = 1'b0;
         end
         7'h03: begin
            legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            d.rf_we = legal; d.mem_re = legal; d.alu_src = 1'b1; d.imm = 32'(v_i);
         end
         7'h23: begin
            legal = (f3 < 3); d.mem_we = legal; d.alu_src = 1'b1; d.imm = 32'(v_s);
         end
         7'h63: begin
            legal = !(f3 == 2 || f3 == 3); d.branch = legal; d.imm = 32'(v_b);
         end
         7'h6F: begin
            d.jump = 1'b1; d.rf_we = 1'b1; d.a_sel = 2'd1; d.imm = 32'(v_j);
         end
         7'h67: begin
            legal = (f3 == 0); d.jump_reg = legal; d.rf_we = legal;
            d.alu_src = 1'b1; d.imm = 32'(v_i);
         end
         7'h37: begin
            d.a_sel = 2'd2; d.alu_src = 1'b1; d.rf_we = 1'b1; d.imm = 32'(v_u);
         end
         7'h17: begin
            d.a_sel = 2'd1; d.alu_src = 1'b1; d.rf_we = 1'b1; d.imm = 32'(v_u);
         end
         default: legal = 1'b0;
      endcase
      d.illegal = !legal;
      return d;
   endfunction

   logic        m_valid = 1'b0;
   dec_t        m_d;
   logic [31:0] m_instr = '0, m_pc = '0;
   int          m_cnt = 0, m_cnt2 = 0;

   task automatic update_model();
      if (rst) begin
         m_valid = 1'b0; m_cnt = 0; m_cnt2 = 0;
      end else if (flush) begin
         m_valid = 1'b0;
      end else if (in_valid && (!m_valid || out_ready)) begin
         m_valid = 1'b1; m_instr = instr; m_pc = pc; m_d = ref_decode(instr);
         if (m_d.illegal) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
         end
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic compare_all();
      check("in_ready", in_ready, !m_valid || out_ready);
      check("out_valid", out_valid, m_valid);
      check("illegal_cnt", illegal_cnt, m_cnt);
      check("illegal_cnt_w2", s_illegal_cnt, m_cnt2);
      if (m_valid) begin
         check("pc_out", pc_out, m_pc);
         check("regs", {rd, rs1, rs2}, {m_instr[11:7], m_instr[19:15], m_instr[24:20]});
         check("strobes", {rf_we, mem_we, mem_re, branch, jump, jump_reg, illegal},
               {m_d.rf_we, m_d.mem_we, m_d.mem_re, m_d.branch, m_d.jump, m_d.jump_reg, m_d.illegal});
         if (!m_d.illegal) begin
            check("alu_ctl", {alu_op, a_sel, alu_src}, {m_d.alu_op, m_d.a_sel, m_d.alu_src});
            if (m_d.imm_chk) check("imm", imm, m_d.imm);
            if (m_d.mem_we || m_d.mem_re) check("mem_size", mem_size, m_instr[14:12]);
            if (m_d.branch) check("br_funct3", br_funct3, m_instr[14:12]);
         end
      end else begin
         check("idle_strobes", {rf_we, mem_we, mem_re, branch, jump, jump_reg, illegal}, 7'd0);
      end
   endtask

   task automatic step();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      update_model();
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r = $urandom;
      logic [6:0]  ops [10] = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
      int          k = $urandom_range(0, 9);
      int          f = $urandom_range(0, 3);
      r[6:0] = (k == 9) ? 7'($urandom) : ops[k];
      if (f == 0) r[31:25] = 7'h00;
      else if (f == 1) r[31:25] = 7'h20;
      return r;
   endfunction

   task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p, input logic ordy);
      in_valid = v; instr = i; pc = p; out_ready = ordy;
   endtask

   initial begin
      repeat (2) begin
         @(posedge clk);
         update_model();
      end
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_cnt", illegal_cnt, 8'd0);
      check("rst_bundle", {pc_out, imm, rd, rs1, rs2, alu_op}, '0);
      @(posedge clk);
      update_model();
      #1 rst = 1'b0;

      drive(1'b1, 32'hFFF0_0093, 32'h0, 1'b1); step();
      check("addi_valid", out_valid, 1'b1);
      check("addi_rd_rs1", {rd, rs1}, {5'd1, 5'd0});
      check("addi_imm", imm, 32'hFFFF_FFFF);
      check("addi_ctl", {alu_op, alu_src, rf_we}, {4'b0000, 1'b1, 1'b1});

      drive(1'b1, 32'h0020_A423, 32'h4, 1'b1); step();
      check("sw_we", {mem_we, rf_we}, 2'b10);
      check("sw_regs", {rs1, rs2}, {5'd1, 5'd2});
      check("sw_imm", imm, 32'd8);
      check("sw_size", mem_size, 3'b010);

      drive(1'b1, 32'hFE00_0EE3, 32'h100, 1'b1); step();
      check("beq_imm", imm, 32'hFFFF_FFFC);
      check("beq_br", {branch, br_funct3}, {1'b1, 3'b000});

      drive(1'b1, 32'h0010_00EF, 32'h200, 1'b1); step();
      check("jal_imm", imm, 32'h0000_0800);
      check("jal_jump_rd", {jump, rd}, {1'b1, 5'd1});
      check("jal_pc", pc_out, 32'h200);

      drive(1'b1, 32'h0020_81B3, 32'h300, 1'b1); step();
      drive(1'b1, 32'h0050_0113, 32'h304, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step();
         check("stall_in_ready", in_ready, 1'b0);
         check("stall_hold", {out_valid, rd, pc_out}, {1'b1, 5'd3, 32'h300});
      end
      out_ready = 1'b1; step();
      check("second_delivered", {out_valid, rd, imm}, {1'b1, 5'd2, 32'd5});
      in_valid = 1'b0; step();
      check("drained", out_valid, 1'b0);

      drive(1'b1, 32'h0, 32'h400, 1'b1);
      for (int k = 0; k < 5; k++) begin
         step();
         check("ill_flags", {illegal, rf_we}, 2'b10);
         if (k == 2) check("ill_cnt3", illegal_cnt, 8'd3);
      end
      check("ill_cnt5", illegal_cnt, 8'd5);
      check("ill_cnt_sat", s_illegal_cnt, 2'd3);

      drive(1'b1, 32'h0020_81B3, 32'h500, 1'b0); step();
      flush = 1'b1; instr = 32'h0050_0113; step();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_clear", out_valid, 1'b0);
      out_ready = 1'b1; step();
      check("flush_nothing", out_valid, 1'b0);

      drive(1'b1, 32'h0, 32'h600, 1'b0); step();
      in_valid = 1'b0; step();
      rst = 1'b1; step();
      rst = 1'b0;
      check("rst_mid_valid", out_valid, 1'b0);
      check("rst_mid_cnt", illegal_cnt, 8'd0);
      out_ready = 1'b1; step();
      check("rst_nothing", out_valid, 1'b0);

      for (int n = 0; n < 3000; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         rst       = ($urandom_range(0, 99) == 0);
         instr     = rand_instr();
         pc        = $urandom & 32'hFFFF_FFFC;
         step();
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
